instruction_encoder: RTL and testbench

//  Packs instruction fields (format, opcode, funct, rt, rs, immediate) into 8-bit words.

---
 rtl/aardvark_isa_pkg.sv | 41 ++++
 rtl/instruction_encoder_if.sv | 53 +++++
 rtl/instr_field_packer.sv | 42 ++++
 rtl/instruction_encoder.sv | 167 ++++++++++++++++
 tb/tb_instruction_encoder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aardvark_isa_pkg.sv
// ---------------------------------------------------------------------------
// aardvark_isa_pkg
// Shared ISA definitions for the 8-bit aardvark instruction word. Both the
// encoder and the instruction register decoder import this package.
//   - instruction format encodings (FMT_R / FMT_I / FMT_J / FMT_RSV)
//   - bit positions of every field inside the packed word
//   - encoder FSM state type
// Optional feature macro: ENC_READBACK_EN adds the VERIFY state.
// ---------------------------------------------------------------------------
package aardvark_isa_pkg;

    localparam int WORD_W = 8;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RSV = 2'd3   // reserved, always rejected
    } fmt_e;

    // Field positions (LSB of each field) within the packed word.
    localparam int OPCODE_LSB = 5;   // word[7:5]   R/I opcode
    localparam int FUNCT_BIT  = 4;   // word[4]     R/I funct
    localparam int RT_LSB     = 2;   // word[3:2]   R rt, I imm[1:0]
    localparam int RS_LSB     = 0;   // word[1:0]   R/I rs
    localparam int JCLS_LSB   = 6;   // word[7:6]   J jump class = opcode[2:1]
    localparam int JIMM_LSB   = 0;   // word[4:0]   J immediate

    // The J-type jump class is the upper two opcode bits.
    localparam int JCLS_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
`ifdef ENC_READBACK_EN
        ST_VERIFY = 2'd2,
`endif
        ST_FULL   = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instruction_encoder_if.sv
// ---------------------------------------------------------------------------
// instruction_encoder_if
// Bundles the field-input handshake, pointer load, memory write/read port and
// status outputs of instruction_encoder.
//   master : program loader / test host side (drives fields, memory read data)
//   slave  : the encoder
// Optional feature macro: ENC_READBACK_EN adds verify_err.
// ---------------------------------------------------------------------------
interface instruction_encoder_if #(
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [2:0]        opcode;
    logic              funct;
    logic [1:0]        rt;
    logic [1:0]        rs;
    logic [4:0]        imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_value;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              err_illegal;
    logic              full;
    logic [ADDR_W:0]   word_count;
`ifdef ENC_READBACK_EN
    logic              verify_err;
`endif

    modport master (
        output in_valid, fmt, opcode, funct, rt, rs, imm,
               addr_load, addr_value, mem_rdata,
        input  in_ready, mem_we, mem_addr, mem_wdata,
`ifdef ENC_READBACK_EN
               verify_err,
`endif
               err_illegal, full, word_count
    );

    modport slave (
        input  in_valid, fmt, opcode, funct, rt, rs, imm,
               addr_load, addr_value, mem_rdata,
        output in_ready, mem_we, mem_addr, mem_wdata,
`ifdef ENC_READBACK_EN
               verify_err,
`endif
               err_illegal, full, word_count
    );

endinterface

// File: rtl/instr_field_packer.sv
// ---------------------------------------------------------------------------
// instr_field_packer
// Purely combinational: packs instruction fields into one 8-bit word and
// flags bundles that cannot be encoded.
//   fmt_i, opcode_i, funct_i, rt_i, rs_i, imm_i : instruction fields
//   word_o    : packed word (R={op,funct,rt,rs}, I={op,funct,imm[1:0],rs},
//               J={op[2:1],0,imm[4:0]})
//   illegal_o : reserved format, or I-type immediate wider than 2 bits
// ---------------------------------------------------------------------------
module instr_field_packer
    import aardvark_isa_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [2:0]  opcode_i,
    input  logic        funct_i,
    input  logic [1:0]  rt_i,
    input  logic [1:0]  rs_i,
    input  logic [4:0]  imm_i,
    output logic [7:0]  word_o,
    output logic        illegal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        word_o    = '0;
        illegal_o = 1'b0;
        case (fmt_i)
            FMT_R: word_o = {opcode_i, funct_i, rt_i, rs_i};
            FMT_I: begin
                word_o    = {opcode_i, funct_i, imm_i[1:0], rs_i};
                illegal_o = |imm_i[4:2];
            end
            // The decoder reads the jump class from word[7:6] and the
            // immediate from word[4:0]; word[5] belongs to neither, so it is
            // packed as 0 and opcode[0] is dropped for J-type.
            FMT_J:   word_o = {opcode_i[2:1], 1'b0, imm_i};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
// Accepts field bundles, packs them (instr_field_packer) and writes each word
// into instruction memory at an auto-incrementing address. Stops accepting
// once address DEPTH-1 has been written; addr_load re-arms it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instruction_encoder_if.slave (fields, pointer load, memory
//                port, err_illegal / full / word_count status)
// Optional feature macro: ENC_READBACK_EN -- after each write (except the
// last address) read the word back for two cycles and set sticky verify_err
// on a mismatch.
// ---------------------------------------------------------------------------
module instruction_encoder
    import aardvark_isa_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_encoder_if.slave bus
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              live_q;   // holds in_ready low until the first clock after reset
`ifdef ENC_READBACK_EN
    logic              verr_q, verr_d;
    logic              vphase_q, vphase_d;
`else
    logic              unused_rdata;
    assign unused_rdata = ^bus.mem_rdata;
`endif

    logic [7:0] packed_word;
    logic       illegal;
    logic       accept;

    instr_field_packer u_packer (
        .fmt_i    (fmt_e'(bus.fmt)),
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .rt_i     (bus.rt),
        .rs_i     (bus.rs),
        .imm_i    (bus.imm),
        .word_o   (packed_word),
        .illegal_o(illegal)
    );

    assign bus.in_ready = live_q && (state_q == ST_IDLE) && !bus.addr_load;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = 1'b0;
`ifdef ENC_READBACK_EN
        verr_d   = verr_q;
        vphase_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.addr_load) begin
                    ptr_d   = bus.addr_value;
                    count_d = '0;
`ifdef ENC_READBACK_EN
                    verr_d  = 1'b0;
`endif
                end else if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = ptr_q;
                        wdata_d = packed_word;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (count_q != DEPTH_C) count_d = count_q + (ADDR_W+1)'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_FULL;
                end else begin
`ifdef ENC_READBACK_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef ENC_READBACK_EN
            // Phase 0 presents the address; memory data arrives in phase 1.
            ST_VERIFY: begin
                vphase_d = 1'b1;
                if (vphase_q) begin
                    if (bus.mem_rdata != wdata_q) verr_d = 1'b1;
                    vphase_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
`endif
            ST_FULL: begin
                if (bus.addr_load) begin
                    ptr_d   = bus.addr_value;
                    count_d = '0;
                    state_d = ST_IDLE;
`ifdef ENC_READBACK_EN
                    verr_d  = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            live_q   <= 1'b0;
`ifdef ENC_READBACK_EN
            verr_q   <= 1'b0;
            vphase_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            err_q    <= err_d;
            live_q   <= 1'b1;
`ifdef ENC_READBACK_EN
            verr_q   <= verr_d;
            vphase_q <= vphase_d;
`endif
        end
    end

    assign bus.mem_we      = (state_q == ST_WRITE);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.err_illegal = err_q;
    assign bus.full        = (state_q == ST_FULL);
    assign bus.word_count  = count_q;
`ifdef ENC_READBACK_EN
    assign bus.verify_err  = verr_q;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_encoder
// Self-checking bench for instruction_encoder (DEPTH=8). Stimulus pushes
// expected memory writes / error pulses into a scoreboard; a monitor on the
// falling edge pops and compares whenever the DUT writes or flags an error.
// Optional feature macro: ENC_READBACK_EN (memory model corrupts address 3).
// ---------------------------------------------------------------------------
module tb_instruction_encoder;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  err_pending = 0;
    int  m_ptr = 0, m_count = 0;
    bit  m_full = 0, m_verr = 0;

    // Word value from the field rules, by plain arithmetic.
    function automatic int ref_word(input int f, input int op, input int fn, input int rt,
                                    input int rs, input int imm, output bit ok);
        ok = 1'b1;
        case (f)
            0: return op * 32 + fn * 16 + rt * 4 + rs;
            1: begin ok = (imm < 4); return op * 32 + fn * 16 + (imm % 4) * 4 + rs; end
            2: return (op / 2) * 64 + imm;
            default: begin ok = 1'b0; return 0; end
        endcase
    endfunction

    // ---------------- memory model ----------------
    logic [7:0] mem [0:31];
    initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (bus.mem_we) begin
`ifdef ENC_READBACK_EN
            if (bus.mem_addr == 5'd3) mem[bus.mem_addr] <= ~bus.mem_wdata;
            else                      mem[bus.mem_addr] <= bus.mem_wdata;
`else
            mem[bus.mem_addr] <= bus.mem_wdata;
`endif
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // ---------------- monitor ----------------
    int n_writes = 0, n_errs = 0;
    int last_addr = -1, last_wdata = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                n_writes++;
                last_addr  = int'(bus.mem_addr);
                last_wdata = int'(bus.mem_wdata);
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
                end
            end
            if (bus.err_illegal) begin
                n_errs++;
                check("err_expected", 32'(err_pending > 0), 32'd1);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int f, input int op, input int fn, input int rt,
                        input int rs, input int imm);
        int  w;
        bit  ok;
        int  waited = 0;
        @(negedge clk);
        bus.fmt = 2'(f); bus.opcode = 3'(op); bus.funct = 1'(fn);
        bus.rt = 2'(rt); bus.rs = 2'(rs); bus.imm = 5'(imm);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        w = ref_word(f, op, fn, rt, rs, imm, ok);
        if (ok) begin
            exp_q.push_back('{addr: m_ptr, data: w});
`ifdef ENC_READBACK_EN
            if (m_ptr == 3 && m_ptr != DEPTH - 1) m_verr = 1'b1;
`endif
            m_ptr++;
            if (m_count < DEPTH) m_count++;
            if (m_ptr == DEPTH) m_full = 1'b1;
        end else begin
            err_pending++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_rand_legal();
        send($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready || bus.full) return;
        end
        check("idle_timeout", 32'(bus.in_ready | bus.full), 32'd1);
    endtask

    task automatic load_addr(input int v);
        wait_idle();
        bus.addr_load  = 1'b1;
        bus.addr_value = ADDR_W'(v);
        #1 check("ready_low_on_load", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.addr_load = 1'b0;
        m_ptr = v; m_count = 0; m_full = 1'b0; m_verr = 1'b0;
    endtask

    task automatic settle_and_check(input string tag);
        repeat (6) @(negedge clk);
        check({tag, "_word_count"}, 32'(bus.word_count), 32'(m_count));
        check({tag, "_full"},       32'(bus.full),       32'(m_full));
        check({tag, "_drained"},    32'(exp_q.size()),   32'd0);
        check({tag, "_err_seen"},   32'(err_pending),    32'd0);
`ifdef ENC_READBACK_EN
        check({tag, "_verify_err"}, 32'(bus.verify_err), 32'(m_verr));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_we"},      32'(bus.mem_we),      32'd0);
        check({tag, "_mem_addr"},    32'(bus.mem_addr),    32'd0);
        check({tag, "_mem_wdata"},   32'(bus.mem_wdata),   32'd0);
        check({tag, "_err_illegal"}, 32'(bus.err_illegal), 32'd0);
        check({tag, "_full"},        32'(bus.full),        32'd0);
        check({tag, "_word_count"},  32'(bus.word_count),  32'd0);
        check({tag, "_in_ready"},    32'(bus.in_ready),    32'd0);
`ifdef ENC_READBACK_EN
        check({tag, "_verify_err"},  32'(bus.verify_err),  32'd0);
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_held_after_release", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 check("ready_first_clk", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int saved_ptr, saved_writes, saved_errs;
        bus.in_valid = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.funct = 1'b0;
        bus.rt = '0; bus.rs = '0; bus.imm = '0;
        bus.addr_load = 1'b0; bus.addr_value = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        release_reset();

        // R-type
        send(0, 2, 1, 2, 1, 0);
        settle_and_check("r");
        check("r_word", 32'(last_wdata), 32'h59);
        check("r_addr", 32'(last_addr), 32'd0);
        check("r_count_one", 32'(bus.word_count), 32'd1);

        // I-type legal and illegal immediate
        send(1, 4, 0, 0, 2, 3);
        settle_and_check("i");
        check("i_word", 32'(last_wdata), 32'h8E);
        saved_writes = n_writes; saved_errs = n_errs;
        send(1, 4, 0, 0, 2, 4);
        settle_and_check("i_bad");
        check("i_bad_no_write", 32'(n_writes), 32'(saved_writes));
        check("i_bad_err_pulse", 32'(n_errs), 32'(saved_errs + 1));

        // J-type; word[5] stays 0 whatever opcode[0] is
        send(2, 6, 0, 0, 0, 21);
        settle_and_check("j");
        check("j_word", 32'(last_wdata), 32'hD5);
        send(2, 7, 1, 3, 3, 21);
        settle_and_check("j_op0");
        check("j_op0_word", 32'(last_wdata), 32'hD5);

        // Reserved format: rejected, pointer unchanged
        saved_ptr = m_ptr; saved_writes = n_writes;
        send(3, 5, 1, 1, 1, 9);
        settle_and_check("rsv");
        check("rsv_no_write", 32'(n_writes), 32'(saved_writes));
        send(0, 1, 0, 1, 2, 0);
        settle_and_check("rsv_next");
        check("rsv_ptr_unchanged", 32'(last_addr), 32'(saved_ptr));

        // Fill all DEPTH words from address 0
        load_addr(0);
        for (int i = 0; i < DEPTH; i++) send_rand_legal();
        settle_and_check("fill");
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_ready", 32'(bus.in_ready), 32'd0);
        check("fill_count", 32'(bus.word_count), 32'(DEPTH));
        check("fill_last_addr", 32'(last_addr), 32'(DEPTH - 1));
        saved_writes = n_writes;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.fmt = 2'd0;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        check("full_no_accept", 32'(n_writes), 32'(saved_writes));

        load_addr(2);
        check("reload_full_clear", 32'(bus.full), 32'd0);
        check("reload_count_clear", 32'(bus.word_count), 32'd0);
        send_rand_legal();
        settle_and_check("reload");
        check("reload_addr", 32'(last_addr), 32'd2);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            if (m_full || $urandom_range(0, 9) == 0) begin
                load_addr($urandom_range(0, DEPTH - 1));
            end else begin
                send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31));
            end
        end
        settle_and_check("rand");

        // Reset during WRITE
        load_addr(4);
        send_rand_legal();
        check("write_state_we", 32'(bus.mem_we), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        err_pending = 0;
        m_ptr = 0; m_count = 0; m_full = 1'b0; m_verr = 1'b0;
        #1 check_all_zero("abort");
        repeat (2) @(negedge clk);
        release_reset();
        send_rand_legal();
        settle_and_check("post_reset");
        check("post_reset_addr", 32'(last_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
